// File: rtl/i2c_wb_sequencer_pkg.sv
// Shared constants, state and error encodings for the I2C core Wishbone sequencer.
package i2c_seq_pkg;

    localparam logic [2:0] ADR_PRERLO = 3'd0;
    localparam logic [2:0] ADR_PRERHI = 3'd1;
    localparam logic [2:0] ADR_CTR    = 3'd2;
    localparam logic [2:0] ADR_TXR    = 3'd3;
    localparam logic [2:0] ADR_RXR    = 3'd3;
    localparam logic [2:0] ADR_CR     = 3'd4;
    localparam logic [2:0] ADR_SR     = 3'd4;

    localparam int CR_STA   = 7;
    localparam int CR_STO   = 6;
    localparam int CR_RD    = 5;
    localparam int CR_WR    = 4;
    localparam int CR_ACK   = 3;
    localparam int SR_RXACK = 7;
    localparam int SR_AL    = 5;
    localparam int SR_TIP   = 1;

    localparam logic [7:0] CTR_EN          = 8'h80;
    localparam logic [7:0] CMD_STA_WR      = 8'h90;
    localparam logic [7:0] CMD_WR          = 8'h10;
    localparam logic [7:0] CMD_WR_STO      = 8'h50;
    localparam logic [7:0] CMD_RD_NACK_STO = 8'h68;
    localparam logic [7:0] CMD_STO         = 8'h40;

    typedef enum logic [3:0] {
        ST_INIT_PRLO,
        ST_INIT_PRHI,
        ST_INIT_CTR,
        ST_IDLE,
        ST_LOAD_TX,
        ST_ISSUE_CR,
        ST_POLL,
        ST_CHECK,
        ST_STOP_CR,
        ST_STOP_POLL,
        ST_READ_RX,
        ST_DONE
    } seq_state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_NACK    = 2'b01,
        ERR_AL      = 2'b10,
        ERR_TIMEOUT = 2'b11
    } rsp_err_e;

    // Write transfers use steps 0..2, reads use 0..3 (step 3 = receive with NACK+STOP).
    function automatic logic [7:0] cr_for_step(input logic rw, input logic [1:0] step);
        case (step)
            2'd0:    return CMD_STA_WR;
            2'd1:    return CMD_WR;
            2'd2:    return rw ? CMD_STA_WR : CMD_WR_STO;
            default: return CMD_RD_NACK_STO;
        endcase
    endfunction

endpackage

// File: rtl/i2c_wb_sequencer_if.sv
// Wishbone link between the sequencer (master) and the I2C core register port (slave).
interface i2c_wb_sequencer_if #(
    parameter int LOW_ADDR_WIDTH = 3,
    parameter int DATABUS_WIDTH  = 8
);
    logic [LOW_ADDR_WIDTH-1:0] wb_adr_o;
    logic [DATABUS_WIDTH-1:0]  wb_dat_o;
    logic [DATABUS_WIDTH-1:0]  wb_dat_i;
    logic                      wb_we_o;
    logic                      wb_stb_o;
    logic                      wb_cyc_o;
    logic                      wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/i2c_wb_sequencer_bus.sv
// Single-access Wishbone cycle engine; one access per start, idle cycle guaranteed after each ack.
module i2c_wb_bus_master #(
    parameter int LOW_ADDR_WIDTH = 3,
    parameter int DATABUS_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      start,
    input  logic                      we,
    input  logic [LOW_ADDR_WIDTH-1:0] adr,
    input  logic [DATABUS_WIDTH-1:0]  wdata,
    output logic                      done,
    output logic [DATABUS_WIDTH-1:0]  rdata,
    i2c_wb_sequencer_if.master        wb
);
    logic                      cyc_q;
    logic                      we_q;
    logic [LOW_ADDR_WIDTH-1:0] adr_q;
    logic [DATABUS_WIDTH-1:0]  dat_q;
    logic                      done_q;
    logic [DATABUS_WIDTH-1:0]  rdata_q;

    // start is ignored while done_q is high, which enforces the idle gap between accesses.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (cyc_q) begin
                if (wb.wb_ack_i) begin
                    cyc_q  <= 1'b0;
                    we_q   <= 1'b0;
                    adr_q  <= '0;
                    dat_q  <= '0;
                    done_q <= 1'b1;
                    if (!we_q) rdata_q <= wb.wb_dat_i;
                end
            end else if (start && !done_q) begin
                cyc_q <= 1'b1;
                we_q  <= we;
                adr_q <= adr;
                dat_q <= wdata;
            end
        end
    end

    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign done        = done_q;
    assign rdata       = rdata_q;

endmodule

// File: rtl/i2c_wb_sequencer.sv
// Initialises the I2C master core and turns single-byte register requests into TXR/CR/SR sequences.
module i2c_wb_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int          LOW_ADDR_WIDTH = 3,
    parameter int          DATABUS_WIDTH  = 8,
    parameter logic [15:0] PRESCALE       = 16'h0063,
    parameter int          POLL_MAX       = 1024
) (
    input  logic               clk,
    input  logic               arst,
    i2c_wb_sequencer_if.master wb,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_rw,
    input  logic [6:0]         req_saddr,
    input  logic [7:0]         req_raddr,
    input  logic [7:0]         req_wdata,
    output logic               rsp_valid,
    output logic [7:0]         rsp_data,
    output logic [1:0]         rsp_err,
    output logic               busy
);
    localparam int PCW = $clog2(POLL_MAX + 1);
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX - 1);

    seq_state_e state, state_n;
    logic [1:0] step, step_n;
    logic [PCW-1:0] poll_cnt, poll_cnt_n;
    logic       lat_rw;
    logic [6:0] lat_saddr;
    logic [7:0] lat_raddr, lat_wdata;
    logic [7:0] rsp_data_q, rsp_data_n;
    rsp_err_e   rsp_err_q, rsp_err_n;

    logic                      acc_start, acc_we, bus_done;
    logic [LOW_ADDR_WIDTH-1:0] acc_adr;
    logic [DATABUS_WIDTH-1:0]  acc_wdata, bus_rdata;
    logic [7:0] sr, cr_val, tx_val;
    logic       last_step;

    i2c_wb_bus_master #(
        .LOW_ADDR_WIDTH (LOW_ADDR_WIDTH),
        .DATABUS_WIDTH  (DATABUS_WIDTH)
    ) u_bus (
        .clk   (clk),
        .arst  (arst),
        .start (acc_start),
        .we    (acc_we),
        .adr   (acc_adr),
        .wdata (acc_wdata),
        .done  (bus_done),
        .rdata (bus_rdata),
        .wb    (wb)
    );

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state      <= ST_INIT_PRLO;
            step       <= '0;
            poll_cnt   <= '0;
            lat_rw     <= 1'b0;
            lat_saddr  <= '0;
            lat_raddr  <= '0;
            lat_wdata  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= ERR_OK;
        end else begin
            state      <= state_n;
            step       <= step_n;
            poll_cnt   <= poll_cnt_n;
            rsp_data_q <= rsp_data_n;
            rsp_err_q  <= rsp_err_n;
            if (state == ST_IDLE && req_valid) begin
                lat_rw    <= req_rw;
                lat_saddr <= req_saddr;
                lat_raddr <= req_raddr;
                lat_wdata <= req_wdata;
            end
        end
    end

    always_comb begin
        state_n    = state;
        step_n     = step;
        poll_cnt_n = poll_cnt;
        rsp_data_n = rsp_data_q;
        rsp_err_n  = rsp_err_q;
        acc_start  = 1'b0;
        acc_we     = 1'b0;
        acc_adr    = '0;
        acc_wdata  = '0;

        sr        = bus_rdata[7:0];
        cr_val    = cr_for_step(lat_rw, step);
        last_step = lat_rw ? (step == 2'd3) : (step == 2'd2);
        case (step)
            2'd0:    tx_val = {lat_saddr, 1'b0};
            2'd1:    tx_val = lat_raddr;
            default: tx_val = lat_rw ? {lat_saddr, 1'b1} : lat_wdata;
        endcase

        case (state)
            ST_INIT_PRLO: begin
                {acc_start, acc_we} = 2'b11;
                acc_adr   = LOW_ADDR_WIDTH'(ADR_PRERLO);
                acc_wdata = DATABUS_WIDTH'(PRESCALE[7:0]);
                if (bus_done) state_n = ST_INIT_PRHI;
            end
            ST_INIT_PRHI: begin
                {acc_start, acc_we} = 2'b11;
                acc_adr   = LOW_ADDR_WIDTH'(ADR_PRERHI);
                acc_wdata = DATABUS_WIDTH'(PRESCALE[15:8]);
                if (bus_done) state_n = ST_INIT_CTR;
            end
            ST_INIT_CTR: begin
                {acc_start, acc_we} = 2'b11;
                acc_adr   = LOW_ADDR_WIDTH'(ADR_CTR);
                acc_wdata = DATABUS_WIDTH'(CTR_EN);
                if (bus_done) state_n = ST_IDLE;
            end
            ST_IDLE: begin
                if (req_valid) begin
                    step_n  = '0;
                    state_n = ST_LOAD_TX;
                end
            end
            ST_LOAD_TX: begin
                if (lat_rw && step == 2'd3) begin
                    state_n = ST_ISSUE_CR;
                end else begin
                    {acc_start, acc_we} = 2'b11;
                    acc_adr   = LOW_ADDR_WIDTH'(ADR_TXR);
                    acc_wdata = DATABUS_WIDTH'(tx_val);
                    if (bus_done) state_n = ST_ISSUE_CR;
                end
            end
            ST_ISSUE_CR: begin
                {acc_start, acc_we} = 2'b11;
                acc_adr   = LOW_ADDR_WIDTH'(ADR_CR);
                acc_wdata = DATABUS_WIDTH'(cr_val);
                if (bus_done) begin
                    poll_cnt_n = '0;
                    state_n    = ST_POLL;
                end
            end
            ST_POLL, ST_STOP_POLL: begin
                acc_start = 1'b1;
                acc_adr   = LOW_ADDR_WIDTH'(ADR_SR);
                if (bus_done) begin
                    if (!sr[SR_TIP]) begin
                        if (state == ST_POLL) begin
                            state_n = ST_CHECK;
                        end else begin
                            state_n    = ST_DONE;
                            rsp_err_n  = ERR_NACK;
                            rsp_data_n = '0;
                        end
                    end else if (poll_cnt == POLL_LAST) begin
                        state_n    = ST_DONE;
                        rsp_err_n  = ERR_TIMEOUT;
                        rsp_data_n = '0;
                    end else begin
                        poll_cnt_n = poll_cnt + 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (sr[SR_AL]) begin
                    state_n    = ST_DONE;
                    rsp_err_n  = ERR_AL;
                    rsp_data_n = '0;
                end else if (cr_val[CR_WR] && sr[SR_RXACK]) begin
                    state_n = ST_STOP_CR;
                end else if (last_step) begin
                    if (lat_rw) begin
                        state_n = ST_READ_RX;
                    end else begin
                        state_n    = ST_DONE;
                        rsp_err_n  = ERR_OK;
                        rsp_data_n = '0;
                    end
                end else begin
                    step_n  = step + 2'd1;
                    state_n = ST_LOAD_TX;
                end
            end
            ST_STOP_CR: begin
                {acc_start, acc_we} = 2'b11;
                acc_adr   = LOW_ADDR_WIDTH'(ADR_CR);
                acc_wdata = DATABUS_WIDTH'(CMD_STO);
                if (bus_done) begin
                    poll_cnt_n = '0;
                    state_n    = ST_STOP_POLL;
                end
            end
            ST_READ_RX: begin
                acc_start = 1'b1;
                acc_adr   = LOW_ADDR_WIDTH'(ADR_RXR);
                if (bus_done) begin
                    state_n    = ST_DONE;
                    rsp_err_n  = ERR_OK;
                    rsp_data_n = bus_rdata[7:0];
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_INIT_PRLO;
        endcase
    end

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_DONE);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule
